sp_uart_tx: RTL
===============

Name: sp_uart_tx

Overview:
- Memory-mapped serial-port transmitter: the responder on the CPU bus window 0xEFF0–0xEFFF, selected by the address decoder's sp_cs.
- Accepts CPU register writes/reads, buffers bytes in a small FIFO and shifts them out on txd as 8N1 frames (optional parity).
- Read data feeds the decoder's sp_do input combinationally.

Parameters:
FIFO_DEPTH, 4, TX FIFO entries (power of two, 2..16)
BAUD_RESET, 16'd433, divisor reset value; bit period = divisor+1 clocks

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cs  in  1  chip select from address decoder (sp_cs)
rw  in  1  bus direction; 0 = CPU read, 1 = CPU write (decoder convention: output enable = ~rw & cs)
addr  in  4  register offset, addr[3:0] of CPU address
di  in  8  write data from CPU
dout  out  8  read data to decoder (sp_do)
txd  out  1  serial output, idle high
irq  out  1  high while TX FIFO empty and shifter idle

Behaviour:
- Reset (async, rst_n=0): FIFO empty, state IDLE, txd=1, divisor=BAUD_RESET, ovf=0, irq=1.
- Registers (offsets from package):
  - 0x0 DATA: write pushes di; read returns 0.
  - 0x1 STATUS: read {3'b0, ovf, busy, tx_empty, tx_full, par_en}; write 1 to bit 4 clears ovf (W1C); other bits read-only.
  - 0x2 BAUD_LO: R/W divisor[7:0].
  - 0x3 BAUD_HI: R/W divisor[15:8].
  - 0x4–0xF: read 0, writes ignored.
- Bus timing: writes take effect on rising clk when cs&rw. dout combinational from addr and current state when cs&~rw; 0 otherwise. Reads have no side effects.
- FIFO full: push dropped, ovf set (sticky); FIFO contents unchanged. Push and pop on the same cycle both take effect; occupancy unchanged.
- Baud counter: loads divisor at each bit start, decrements to 0; bit boundary at count==0. Divisor 0 gives 1-clock bits. Divisor written mid-frame is used from the next bit boundary.
- FSM:
  - IDLE: if FIFO not empty, pop into shifter, go START.
  - START: txd=0 for one bit.
  - DATA: 8 bits, LSB first, bit index 0..7.
  - PARITY: only with feature enabled.
  - STOP: txd=1 for one bit, then IDLE.
- Pop latency: byte written into an empty idle FIFO appears as start bit (txd falls) on the 2nd clock after the write edge.
- Back-to-back frames: no idle gap beyond the IDLE cycle.
- busy = state != IDLE. tx_empty = FIFO empty. irq = tx_empty & ~busy.
- Reset mid-frame: txd returns high immediately (async); frame aborted; FIFO flushed.

Optional Feature:
- Macro SP_UART_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP, sending even parity (XOR of the 8 data bits); STATUS bit 0 (par_en) reads 1.
- Undefined: no PARITY state; 10-bit frames; par_en reads 0.

Decomposition:
- Package sp_pkg:
  - register offset constants (SP_DATA=4'h0, SP_STATUS=4'h1, SP_BAUD_LO=4'h2, SP_BAUD_HI=4'h3)
  - STATUS bit index constants
  - FSM state enum tx_state_t {IDLE, START, DATA, PARITY, STOP}
- Sub-module sp_fifo: parameterised synchronous FIFO (push, pop, din, dout, full, empty, async active-low reset); depth from FIFO_DEPTH.

Test Plan:
- Reset, read STATUS (cs=1, rw=0, addr=1) -> dout=8'h04 (tx_empty); txd=1; irq=1.
- Write BAUD_LO=3, BAUD_HI=0, DATA=0xA5 -> txd 0,1,0,1,0,0,1,0,1,1, each level for 4 clocks (40 clocks total); irq back to 1 after stop bit.
- Divisor 0, write 0x01,0x02,0x03 on consecutive cycles -> three back-to-back 10-clock frames; txd high exactly 1 cycle (IDLE) between stop and next start.
- Divisor 100, write 6 bytes while first frame in flight (depth 4) -> bytes 1–5 accepted (1 in shifter, 4 in FIFO), 6th dropped, STATUS=8'h1A (ovf, busy, full). Write STATUS=0x10 -> ovf clears.
- Assert rst_n=0 during DATA bit 3 -> txd=1 same cycle without clock; after release STATUS=8'h04, BAUD reads BAUD_RESET.
- With SP_UART_PARITY_EN, divisor 0, send 0x07 -> 11-bit frame with parity bit 1; STATUS bit 0 reads 1.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared definitions for the serial-port transmitter: register map, STATUS bit layout, FSM states.
package sp_pkg;

    localparam logic [3:0] SP_DATA    = 4'h0;
    localparam logic [3:0] SP_STATUS  = 4'h1;
    localparam logic [3:0] SP_BAUD_LO = 4'h2;
    localparam logic [3:0] SP_BAUD_HI = 4'h3;

    localparam int unsigned ST_PAR_EN   = 0;
    localparam int unsigned ST_TX_FULL  = 1;
    localparam int unsigned ST_TX_EMPTY = 2;
    localparam int unsigned ST_BUSY     = 3;
    localparam int unsigned ST_OVF      = 4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

endpackage

// File: rtl/sp_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module sp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sp_uart_tx.sv
// Serial-port transmitter on the CPU bus: register file, TX FIFO and 8N1 shifter.
// Define SP_UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module sp_uart_tx
    import sp_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RESET = 16'd433
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       rw,
    input  logic [3:0] addr,
    input  logic [7:0] di,
    output logic [7:0] dout,
    output logic       txd,
    output logic       irq
);

`ifdef SP_UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    tx_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  data_q, data_d;
    logic        txd_q, txd_d;
    logic [15:0] divisor_q;
    logic        ovf_q;

    logic       bus_wr, push, pop, fifo_full, fifo_empty, busy, bit_done;
    logic [7:0] fifo_dout, status;

    assign bus_wr   = cs & rw;
    assign push     = bus_wr && (addr == SP_DATA);
    assign busy     = (state_q != IDLE);
    assign bit_done = (cnt_q == '0);
    assign irq      = fifo_empty & ~busy;
    assign txd      = txd_q;
    assign status   = {3'b000, ovf_q, busy, fifo_empty, fifo_full, PAR_EN};

    sp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (di),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        dout = 8'h00;
        if (cs && !rw) begin
            case (addr)
                SP_STATUS:  dout = status;
                SP_BAUD_LO: dout = divisor_q[7:0];
                SP_BAUD_HI: dout = divisor_q[15:8];
                default:    dout = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor_q <= BAUD_RESET;
            ovf_q     <= 1'b0;
        end else if (bus_wr) begin
            case (addr)
                SP_DATA:    if (fifo_full) ovf_q <= 1'b1;
                SP_STATUS:  if (di[ST_OVF]) ovf_q <= 1'b0;
                SP_BAUD_LO: divisor_q[7:0]  <= di;
                SP_BAUD_HI: divisor_q[15:8] <= di;
                default:    ;
            endcase
        end
    end

    // txd is registered from the current state, so the line lags the FSM by one clock.
    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_done ? divisor_q : cnt_q - 16'd1;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        pop       = 1'b0;
        txd_d     = 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = divisor_q;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    data_d    = fifo_dout;
                    bit_idx_d = 3'd0;
                    state_d   = START;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                txd_d = data_q[bit_idx_q];
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef SP_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef SP_UART_PARITY_EN
            PARITY: begin
                txd_d = ^data_q;
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                txd_d = 1'b1;
                if (bit_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            txd_q     <= txd_d;
        end
    end

endmodule
